// File: rtl/dice_roll_controller_if.sv
// Key inputs, random source and roll status for dice_roll_controller.
// master: the board/bench side; slave: the controller.
interface dice_roll_controller_if;
  logic       key0;
  logic       key1;
  logic       key2;
  logic [7:0] rnd_value;
  logic [2:0] selected_dice;
  logic       roll_start;
  logic       roll_busy;
  logic [7:0] value;
  logic       value_valid;

  modport master (
    output key0, key1, key2, rnd_value,
    input  selected_dice, roll_start, roll_busy, value, value_valid
  );

  modport slave (
    input  key0, key1, key2, rnd_value,
    output selected_dice, roll_start, roll_busy, value, value_valid
  );
endinterface

// File: rtl/dice_roll_controller.sv
// Dice selector/roller: debounced keys pick a die, KEY1 rolls for ROLL_CYCLES and latches a clamped result.
// Optional macro DICE_ANIM_EN animates value during a roll every 2^20 cycles.
module dice_roll_controller #(
  parameter int DEFAULT_DICE    = 0,
  parameter int NUM_DICE        = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROLL_CYCLES     = 25000000
) (
  input logic                    clk,
  input logic                    rst_n,
  dice_roll_controller_if.slave  bus
);
  localparam int              DBW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int              RCW      = $clog2(ROLL_CYCLES + 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0]  RC_LAST  = RCW'(ROLL_CYCLES - 1);
  localparam logic [2:0]      SEL_LAST = 3'(NUM_DICE - 1);
  localparam logic [2:0]      SEL_RST  = 3'(DEFAULT_DICE);

  typedef enum logic [1:0] {IDLE, ROLL, SHOW} state_t;

  logic [2:0] key_raw;
  logic [2:0] press;

  assign key_raw = {bus.key2, bus.key1, bus.key0};

  // Synchronizers reset low so a key held through reset never looks released;
  // a key must be seen released (armed) before its first press can count.
  for (genvar k = 0; k < 3; k++) begin : g_key
    logic [1:0]     sync_q;
    logic           deb_q;
    logic           armed_q;
    logic           press_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= 2'b00;
        deb_q   <= 1'b1;
        armed_q <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q  <= {sync_q[0], key_raw[k]};
        press_q <= 1'b0;
        if (sync_q[1] == deb_q) begin
          cnt_q <= '0;
          if (deb_q) armed_q <= 1'b1;
        end else if (cnt_q == DB_LAST) begin
          cnt_q   <= '0;
          deb_q   <= sync_q[1];
          press_q <= armed_q & ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[k] = press_q;
  end

  function automatic logic [7:0] faces(input logic [2:0] idx);
    case (idx)
      3'd0:    faces = 8'd4;
      3'd1:    faces = 8'd6;
      3'd2:    faces = 8'd8;
      3'd3:    faces = 8'd10;
      3'd4:    faces = 8'd12;
      3'd5:    faces = 8'd20;
      default: faces = 8'd6;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     sel_q, sel_d;
  logic [7:0]     value_q, value_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           start_q, start_d;
  logic [7:0]     face_max;
  logic [7:0]     clamped;

  assign face_max = faces(sel_q);
  assign clamped  = (bus.rnd_value != 8'd0 && bus.rnd_value <= face_max) ? bus.rnd_value : face_max;

`ifdef DICE_ANIM_EN
  logic [19:0] anim_q, anim_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) anim_q <= '0;
    else        anim_q <= anim_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    value_d = value_q;
    rcnt_d  = rcnt_q;
    start_d = 1'b0;
`ifdef DICE_ANIM_EN
    anim_d  = anim_q;
`endif
    case (state_q)
      IDLE, SHOW: begin
        if (press[1]) begin
          state_d = ROLL;
          start_d = 1'b1;
          rcnt_d  = '0;
          value_d = 8'd0;
`ifdef DICE_ANIM_EN
          anim_d  = '0;
`endif
        end else if (press[0] && !press[2]) begin
          sel_d   = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
          state_d = IDLE;
          value_d = 8'd0;
        end else if (press[2] && !press[0]) begin
          sel_d   = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
          state_d = IDLE;
          value_d = 8'd0;
        end
      end
      ROLL: begin
`ifdef DICE_ANIM_EN
        anim_d = anim_q + 20'd1;
        if (anim_q == '1) value_d = clamped;
`endif
        if (rcnt_q == RC_LAST) begin
          value_d = clamped;
          state_d = SHOW;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_RST;
      value_q <= 8'd0;
      rcnt_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      value_q <= value_d;
      rcnt_q  <= rcnt_d;
      start_q <= start_d;
    end
  end

  assign bus.selected_dice = sel_q;
  assign bus.roll_start    = start_q;
  assign bus.roll_busy     = (state_q == ROLL);
  assign bus.value         = value_q;
  assign bus.value_valid   = (state_q == SHOW);
endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench for dice_roll_controller: selection, debounce, roll timing/clamping, reset behaviour.
module tb_dice_roll_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  dice_roll_controller_if bus();

  dice_roll_controller #(
    .DEFAULT_DICE    (0),
    .NUM_DICE        (6),
    .DEBOUNCE_CYCLES (4),
    .ROLL_CYCLES     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bit0=KEY0, bit1=KEY1, bit2=KEY2; all masked keys fall together
  task automatic press_keys(input logic [2:0] mask);
    if (mask[0]) bus.key0 = 1'b0;
    if (mask[1]) bus.key1 = 1'b0;
    if (mask[2]) bus.key2 = 1'b0;
    cycles(10);
    bus.key0 = 1'b1;
    bus.key1 = 1'b1;
    bus.key2 = 1'b1;
    cycles(10);
  endtask

  task automatic wait_start(output bit seen);
    int n;
    n = 0;
    while (bus.roll_start !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    seen = (bus.roll_start === 1'b1);
  endtask

  // i=0 is the cycle roll_start is high; result must be valid at i=16
  task automatic do_roll(input string tag, input logic [7:0] rnd, input int exp_v, input bit poke_inc);
    bit seen;
    int busy_n, start_n, valid_at, max_v;
    bus.rnd_value = rnd;
    bus.key1 = 1'b0;
    wait_start(seen);
    check({tag, "_start_seen"}, int'(seen), 1);
    busy_n = 0; start_n = 0; valid_at = -1; max_v = 0;
    for (int i = 0; i <= 20; i++) begin
      if (poke_inc && i == 1)  bus.key0 = 1'b0;
      if (poke_inc && i == 12) bus.key0 = 1'b1;
      if (bus.roll_busy === 1'b1) begin
        busy_n++;
        if (int'(bus.value) > max_v) max_v = int'(bus.value);
      end
      if (bus.roll_start === 1'b1) start_n++;
      if (bus.value_valid === 1'b1 && valid_at < 0) valid_at = i;
      @(negedge clk);
    end
    check({tag, "_start_pulses"}, start_n, 1);
    check({tag, "_busy_cycles"}, busy_n, 16);
    check({tag, "_valid_at"}, valid_at, 16);
    check({tag, "_value_in_roll"}, max_v, 0);
    check({tag, "_value"}, int'(bus.value), exp_v);
    check({tag, "_valid"}, int'(bus.value_valid), 1);
    bus.key1 = 1'b1;
    cycles(10);
  endtask

  initial begin
    bit seen;
    int starts, valids, sel_bad;
    int exp_sel [6] = '{1, 2, 3, 4, 5, 0};

    rst_n = 1'b0;
    bus.key0 = 1'b1; bus.key1 = 1'b1; bus.key2 = 1'b1;
    bus.rnd_value = 8'd0;
    cycles(3);
    check("rst_sel", int'(bus.selected_dice), 0);
    check("rst_value", int'(bus.value), 0);
    check("rst_valid", int'(bus.value_valid), 0);
    check("rst_busy", int'(bus.roll_busy), 0);
    check("rst_start", int'(bus.roll_start), 0);
    rst_n = 1'b1;
    cycles(10);

    for (int i = 0; i < 6; i++) begin
      press_keys(3'b001);
      check($sformatf("inc_%0d", i), int'(bus.selected_dice), exp_sel[i]);
    end

    press_keys(3'b100);
    check("dec_wrap", int'(bus.selected_dice), 5);
    press_keys(3'b101);
    check("inc_dec_same", int'(bus.selected_dice), 5);
    check("inc_dec_valid", int'(bus.value_valid), 0);

    // bounce with segments shorter than the debounce window, then stable low
    bus.key0 = 1'b0; cycles(2);
    bus.key0 = 1'b1; cycles(2);
    bus.key0 = 1'b0; cycles(2);
    bus.key0 = 1'b1; cycles(1);
    bus.key0 = 1'b0; cycles(12);
    bus.key0 = 1'b1; cycles(10);
    check("bounce_one_inc", int'(bus.selected_dice), 0);

    press_keys(3'b001);
    check("sel_1", int'(bus.selected_dice), 1);

    do_roll("roll9", 8'd9, 6, 1'b0);
    do_roll("roll3", 8'd3, 3, 1'b0);
    do_roll("roll0", 8'd0, 6, 1'b0);
    do_roll("roll_key0", 8'd5, 5, 1'b1);
    check("roll_ignores_inc", int'(bus.selected_dice), 1);

    press_keys(3'b001);
    check("show_inc_sel", int'(bus.selected_dice), 2);
    check("show_inc_valid", int'(bus.value_valid), 0);
    check("show_inc_value", int'(bus.value), 0);
    check("show_inc_busy", int'(bus.roll_busy), 0);

    // reset at roll cycle 8, KEY0 held low across reset release
    bus.rnd_value = 8'd2;
    bus.key1 = 1'b0;
    wait_start(seen);
    check("mid_start_seen", int'(seen), 1);
    cycles(7);
    check("mid_busy_before", int'(bus.roll_busy), 1);
    bus.key1 = 1'b1;
    bus.key0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", int'(bus.selected_dice), 0);
    check("mid_rst_busy", int'(bus.roll_busy), 0);
    check("mid_rst_valid", int'(bus.value_valid), 0);
    check("mid_rst_value", int'(bus.value), 0);
    check("mid_rst_start", int'(bus.roll_start), 0);
    cycles(3);
    rst_n = 1'b1;
    starts = 0; valids = 0; sel_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.roll_start === 1'b1) starts++;
      if (bus.value_valid === 1'b1) valids++;
      if (bus.selected_dice !== 3'd0) sel_bad++;
    end
    check("post_rst_starts", starts, 0);
    check("post_rst_valids", valids, 0);
    check("held_key_no_press", sel_bad, 0);
    bus.key0 = 1'b1;
    cycles(10);
    press_keys(3'b001);
    check("post_rst_inc", int'(bus.selected_dice), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/dice_roll_controller.md
DICE_ROLL_CONTROLLER -- requirements
Module: dice_roll_controller

Interface
REQ-001 Parameter DEFAULT_DICE, default 0: dice index loaded at reset.
REQ-002 Parameter NUM_DICE, default 6: number of dice types, legal indices 0..NUM_DICE-1 (max 8).
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: stable-sample count required to accept a key level.
REQ-004 Parameter ROLL_CYCLES, default 25000000: duration of a roll in Clk cycles.
REQ-005 Clk  in  1  system clock, all logic on rising edge.
REQ-006 Rst_n  in  1  asynchronous, active-low reset.
REQ-007 KEY0  in  1  raw push button, active-low, increment selection.
REQ-008 KEY1  in  1  raw push button, active-low, launch roll.
REQ-009 KEY2  in  1  raw push button, active-low, decrement selection.
REQ-010 rnd_value  in  8  free-running random value from the dice datapath.
REQ-011 selected_dice  out  3  current dice index.
REQ-012 roll_start  out  1  one-cycle pulse when a roll begins.
REQ-013 roll_busy  out  1  high while rolling.
REQ-014 value  out  8  rolled result.
REQ-015 value_valid  out  1  high while value holds a final result.

Function
REQ-016 Each KEYn SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-017 A press SHALL be a debounced 1->0 transition, producing exactly one single-cycle internal press pulse; holding a key SHALL not repeat.
REQ-018 Face table by index: 0->4, 1->6, 2->8, 3->10, 4->12, 5->20, 6..7->6.
REQ-019 FSM states IDLE, ROLL, SHOW; reset state IDLE.
REQ-020 IDLE/SHOW, inc press only: selected_dice+1, wrap NUM_DICE-1->0.
REQ-021 IDLE/SHOW, dec press only: selected_dice-1, wrap 0->NUM_DICE-1.
REQ-022 Inc and dec press in same cycle: selection unchanged, state unchanged.
REQ-023 In SHOW, any accepted selection change SHALL clear value_valid, set value to 0 and go to IDLE next cycle.
REQ-024 Roll press in IDLE or SHOW (takes priority over inc/dec same cycle): next cycle state ROLL, roll_start=1 one cycle, roll_busy=1, value_valid=0, roll counter cleared.
REQ-025 In ROLL all key presses SHALL be ignored; counter increments each cycle.
REQ-026 When counter reaches ROLL_CYCLES-1: value <= rnd_value if 1<=rnd_value<=faces(selected_dice), else faces(selected_dice); next cycle state SHOW, roll_busy=0, value_valid=1.
REQ-027 Roll latency from press pulse to value_valid high SHALL be exactly ROLL_CYCLES+1 cycles.

Reset
REQ-028 Rst_n low SHALL immediately force: state IDLE, selected_dice=DEFAULT_DICE, value=0, value_valid=0, roll_busy=0, roll_start=0, debouncers to released (1), counters 0.
REQ-029 Reset asserted mid-roll SHALL abort the roll with no roll_start or value_valid after release until a new press.
REQ-030 After reset release, keys held low SHALL not generate a press until released and pressed again.

Configuration
REQ-031 Macro DICE_ANIM_EN defined: during ROLL, value SHALL update every 2^20 cycles with clamped rnd_value (REQ-026 rule), value_valid stays 0.
REQ-032 DICE_ANIM_EN undefined: value SHALL hold 0 throughout ROLL; no animation logic instantiated.

Verification (DEBOUNCE_CYCLES=4, ROLL_CYCLES=16, NUM_DICE=6, DEFAULT_DICE=0)
REQ-033 Reset, press KEY0 six times -> selected_dice 1,2,3,4,5,0.
REQ-034 From 0, press KEY2 once -> selected_dice=5; KEY0 and KEY2 pressed same cycle -> unchanged.
REQ-035 KEY0 bounce 1-0-1-0 each shorter than 4 cycles then stable low -> exactly one increment.
REQ-036 Index 1, rnd_value=9, KEY1 press -> roll_start one pulse, roll_busy 16 cycles, value=6, value_valid=1 at press+17; rnd_value=3 -> value=3; rnd_value=0 -> value=6.
REQ-037 KEY0 pressed during ROLL -> ignored; KEY0 in SHOW -> selection +1, value_valid=0, value=0, state IDLE.
REQ-038 Rst_n low at cycle 8 of ROLL -> all outputs reset values, no value_valid after release.
